// File: rtl/cpu_pkg.sv
// Shared core constants and helpers for the MEM/WB pipeline register.
package cpu_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RADDR_W = 5;

  localparam logic [DEF_DATA_W-1:0]  ZERO_WORD = '0;
  localparam logic [DEF_RADDR_W-1:0] NOP_REG   = '0;

  function automatic logic [7:0] popcount(input logic [31:0] v);
    logic [7:0] n;
    n = '0;
    for (int k = 0; k < 32; k++) n = n + {7'd0, v[k]};
    return n;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM-side inputs, WB-side outputs and control of the MEM/WB register.
interface mem_wb_pipe_if #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
);
  logic [LANES-1:0]         mem_valid;
  logic [LANES-1:0]         mem_wreg;
  logic [LANES*RADDR_W-1:0] mem_wd;
  logic [LANES*DATA_W-1:0]  mem_wdata;
  logic                     mem_whilo;
  logic [DATA_W-1:0]        mem_hi;
  logic [DATA_W-1:0]        mem_lo;
  logic                     stall_mem;
  logic                     stall_wb;
  logic                     flush;
  logic                     cnt_clr;
  logic [LANES-1:0]         wb_valid;
  logic [LANES-1:0]         wb_wreg;
  logic [LANES*RADDR_W-1:0] wb_wd;
  logic [LANES*DATA_W-1:0]  wb_wdata;
  logic                     wb_whilo;
  logic [DATA_W-1:0]        wb_hi;
  logic [DATA_W-1:0]        wb_lo;
  logic [CNT_W-1:0]         retire_cnt;

  modport master (
    output mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output stall_mem, stall_wb, flush, cnt_clr,
    input  wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, retire_cnt
  );

  modport slave (
    input  mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  stall_mem, stall_wb, flush, cnt_clr,
    output wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, retire_cnt
  );
endinterface

// File: rtl/mem_wb_lane.sv
// One lane of the MEM/WB register: clear wins over capture, otherwise holds.
module mem_wb_lane
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic               i_wreg,
  input  logic [RADDR_W-1:0] i_wd,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic               o_valid,
  output logic               o_wreg,
  output logic [RADDR_W-1:0] o_wd,
  output logic [DATA_W-1:0]  o_wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clr) begin
      o_valid <= 1'b0;
      o_wreg  <= 1'b0;
      o_wd    <= RADDR_W'(NOP_REG);
      o_wdata <= DATA_W'(ZERO_WORD);
    end else if (i_en) begin
      o_valid <= i_valid;
      o_wreg  <= i_wreg;
      o_wd    <= i_wd;
      o_wdata <= i_wdata;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with stall/flush, r0 drop, same-destination
// write collapsing, shared HI/LO write and a retired-instruction counter.
module mem_wb_pipe
  import cpu_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  mem_wb_pipe_if.slave bus
);

  logic             w_clr;
  logic             w_adv;
  logic [LANES-1:0] w_surv;
  logic [LANES-1:0] w_wreg;
  logic [CNT_W-1:0] w_inc;
  logic             r_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;

  // Flush beats everything; a MEM-only stall pushes a bubble; a WB stall holds.
  assign w_clr = bus.flush | (bus.stall_mem & ~bus.stall_wb);
  assign w_adv = ~bus.flush & ~bus.stall_mem & ~bus.stall_wb;
  assign w_inc = CNT_W'(popcount(32'(bus.mem_valid)));

  // A lane's write is suppressed when any younger lane writes the same register.
  always_comb begin
    w_surv = '0;
    w_wreg = '0;
    for (int i = 0; i < LANES; i++)
      w_surv[i] = bus.mem_valid[i] & bus.mem_wreg[i] &
                  (bus.mem_wd[i*RADDR_W +: RADDR_W] != RADDR_W'(NOP_REG));
    for (int i = 0; i < LANES; i++) begin
      w_wreg[i] = w_surv[i];
      for (int j = i + 1; j < LANES; j++)
        if (w_surv[j] && (bus.mem_wd[j*RADDR_W +: RADDR_W] == bus.mem_wd[i*RADDR_W +: RADDR_W]))
          w_wreg[i] = 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic w_v;
    assign w_v = bus.mem_valid[g];

    mem_wb_lane #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_en    (w_adv),
      .i_valid (w_v),
      .i_wreg  (w_wreg[g]),
      .i_wd    (w_v ? bus.mem_wd[g*RADDR_W +: RADDR_W] : RADDR_W'(NOP_REG)),
      .i_wdata (w_v ? bus.mem_wdata[g*DATA_W +: DATA_W] : DATA_W'(ZERO_WORD)),
      .o_valid (bus.wb_valid[g]),
      .o_wreg  (bus.wb_wreg[g]),
      .o_wd    (bus.wb_wd[g*RADDR_W +: RADDR_W]),
      .o_wdata (bus.wb_wdata[g*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_clr) begin
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_adv) begin
      r_whilo <= bus.mem_whilo & (|bus.mem_valid);
      r_hi    <= bus.mem_hi;
      r_lo    <= bus.mem_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cnt <= '0;
    else if (bus.cnt_clr)  r_cnt <= '0;
    else if (w_adv)        r_cnt <= r_cnt + w_inc;
  end

  assign bus.wb_whilo   = r_whilo;
  assign bus.wb_hi      = r_hi;
  assign bus.wb_lo      = r_lo;
  assign bus.retire_cnt = r_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (LANES=2, CNT_W=4 so the wrap is reachable).
module tb_mem_wb_pipe;

  localparam int LANES = 2, DATA_W = 32, RADDR_W = 5, CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  mem_wb_pipe_if #(.LANES(LANES), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

  mem_wb_pipe #(.LANES(LANES), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic [1:0] v, input logic [1:0] w,
                       input logic [4:0] wd0, input logic [4:0] wd1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.mem_valid = v;
    bus.mem_wreg  = w;
    bus.mem_wd    = {wd1, wd0};
    bus.mem_wdata = {d1, d0};
  endtask

  task automatic ctl(input logic sm, input logic sw, input logic fl, input logic cc);
    bus.stall_mem = sm;
    bus.stall_wb  = sw;
    bus.flush     = fl;
    bus.cnt_clr   = cc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(bus.wb_valid), 64'd0);
    chk({tag, ".wreg"},  64'(bus.wb_wreg),  64'd0);
    chk({tag, ".wd"},    64'(bus.wb_wd),    64'd0);
    chk({tag, ".wdata"}, bus.wb_wdata,      64'd0);
    chk({tag, ".whilo"}, 64'(bus.wb_whilo), 64'd0);
    chk({tag, ".hilo"},  {bus.wb_hi, bus.wb_lo}, 64'd0);
  endtask

  initial begin
    lanes(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_whilo = 1'b0;
    bus.mem_hi    = '0;
    bus.mem_lo    = '0;
    #12;
    chk_zero("por");
    chk("por.cnt", 64'(bus.retire_cnt), 64'd0);
    rst = 1'b0;

    // Make outputs nonzero, then reset mid-cycle.
    lanes(2'b01, 2'b01, 5'd5, 5'd0, 32'h55, 32'd0);
    bus.mem_whilo = 1'b1; bus.mem_hi = 32'h1; bus.mem_lo = 32'h2;
    step();
    chk("pre.wdata0", 64'(bus.wb_wdata[31:0]), 64'h55);
    chk("pre.cnt",    64'(bus.retire_cnt), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk_zero("arst");
    chk("arst.cnt", 64'(bus.retire_cnt), 64'd0);
    #1 rst = 1'b0;
    bus.mem_whilo = 1'b0; bus.mem_hi = '0; bus.mem_lo = '0;

    lanes(2'b01, 2'b01, 5'd3, 5'd0, 32'h12345678, 32'd0);
    step();
    chk("adv.wd0",    64'(bus.wb_wd[4:0]), 64'd3);
    chk("adv.wdata0", 64'(bus.wb_wdata[31:0]), 64'h12345678);
    chk("adv.wreg",   64'(bus.wb_wreg), 64'b01);
    chk("adv.valid",  64'(bus.wb_valid), 64'b01);
    chk("adv.cnt",    64'(bus.retire_cnt), 64'd1);

    // Same destination in both lanes: the younger lane keeps the write.
    lanes(2'b11, 2'b11, 5'd7, 5'd7, 32'hA, 32'hB);
    step();
    chk("col.wreg",   64'(bus.wb_wreg), 64'b10);
    chk("col.wdata1", 64'(bus.wb_wdata[63:32]), 64'hB);
    chk("col.wdata0", 64'(bus.wb_wdata[31:0]), 64'hA);
    chk("col.wd",     64'(bus.wb_wd), 64'({5'd7, 5'd7}));
    chk("col.cnt",    64'(bus.retire_cnt), 64'd3);

    lanes(2'b11, 2'b11, 5'd0, 5'd0, 32'hC, 32'hD);
    step();
    chk("r0.wreg",  64'(bus.wb_wreg), 64'b00);
    chk("r0.valid", 64'(bus.wb_valid), 64'b11);
    chk("r0.cnt",   64'(bus.retire_cnt), 64'd5);

    // Invalid lane stores zeros even with nonzero inputs.
    lanes(2'b10, 2'b11, 5'd6, 5'd8, 32'hEE, 32'h88);
    step();
    chk("inv.lane0", {32'(bus.wb_wd[4:0]), bus.wb_wdata[31:0]}, 64'd0);
    chk("inv.wreg",  64'(bus.wb_wreg), 64'b10);
    chk("inv.cnt",   64'(bus.retire_cnt), 64'd6);

    lanes(2'b11, 2'b11, 5'd4, 5'd9, 32'h44, 32'h99);
    step();
    chk("pre_hold.wreg", 64'(bus.wb_wreg), 64'b11);
    chk("pre_hold.cnt",  64'(bus.retire_cnt), 64'd8);

    for (int k = 0; k < 3; k++) begin
      ctl(k[0], 1'b1, 1'b0, 1'b0);
      lanes(2'b11, 2'b11, 5'(k + 10), 5'(k + 20), 32'(k), 32'(k + 100));
      step();
      chk("hold.wdata", bus.wb_wdata, {32'h99, 32'h44});
      chk("hold.wd",    64'(bus.wb_wd), 64'({5'd9, 5'd4}));
      chk("hold.cnt",   64'(bus.retire_cnt), 64'd8);
    end

    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_zero("bubble");
    chk("bubble.cnt", 64'(bus.retire_cnt), 64'd8);

    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    lanes(2'b01, 2'b01, 5'd2, 5'd0, 32'h22, 32'd0);
    step();
    chk("pre_fl.wdata0", 64'(bus.wb_wdata[31:0]), 64'h22);
    chk("pre_fl.cnt",    64'(bus.retire_cnt), 64'd9);

    ctl(1'b0, 1'b1, 1'b1, 1'b0);
    lanes(2'b11, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6);
    step();
    chk_zero("flush");
    chk("flush.cnt", 64'(bus.retire_cnt), 64'd9);

    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    lanes(2'b01, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.mem_whilo = 1'b1; bus.mem_hi = 32'hFFFF0000; bus.mem_lo = 32'h0000FFFF;
    step();
    chk("hl.whilo", 64'(bus.wb_whilo), 64'd1);
    chk("hl.data",  {bus.wb_hi, bus.wb_lo}, 64'hFFFF0000_0000FFFF);
    chk("hl.cnt",   64'(bus.retire_cnt), 64'd10);

    lanes(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.mem_hi = 32'h1234; bus.mem_lo = 32'h5678;
    step();
    chk("hlinv.whilo", 64'(bus.wb_whilo), 64'd0);
    chk("hlinv.data",  {bus.wb_hi, bus.wb_lo}, 64'h00001234_00005678);
    chk("hlinv.cnt",   64'(bus.retire_cnt), 64'd10);
    bus.mem_whilo = 1'b0;

    // Clear overrides a same-cycle increment.
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    lanes(2'b11, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    step();
    chk("clr.cnt",   64'(bus.retire_cnt), 64'd0);
    chk("clr.valid", 64'(bus.wb_valid), 64'b11);

    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step();
    chk("pre_wrap.cnt", 64'(bus.retire_cnt), 64'd14);
    step();
    chk("wrap.cnt", 64'(bus.retire_cnt), 64'd0);

    ctl(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("clrfl.cnt", 64'(bus.retire_cnt), 64'd0);
    chk_zero("clrfl");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register for the multi-issue core. It carries up to LANES register-file write requests plus a shared HI/LO write from the memory stage to write-back. It adds stall and flush control, per-lane valid bits, and same-destination write collapsing. It sits between the MEM stage and the register file / HI-LO unit, and also keeps a retired-instruction counter for the performance block.

## Interface
- LANES, 2, number of issue lanes; lane 0 is the oldest instruction.
- DATA_W, 32, register and HI/LO data width.
- RADDR_W, 5, register address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_valid  in  LANES  lane holds a real instruction.
- mem_wreg  in  LANES  lane requests a register write.
- mem_wd  in  LANES*RADDR_W  destination register per lane, lane i at bits [i*RADDR_W +: RADDR_W].
- mem_wdata  in  LANES*DATA_W  write data per lane, packed the same way.
- mem_whilo  in  1  HI/LO write request.
- mem_hi, mem_lo  in  DATA_W  HI/LO write data.
- stall_mem  in  1  stall request for the MEM stage, from the control unit.
- stall_wb  in  1  stall request for the WB stage, from the control unit.
- flush  in  1  squash the register contents (exception or branch recovery).
- cnt_clr  in  1  synchronous clear of the retire counter.
- wb_valid, wb_wreg  out  LANES  registered lane valid and write enable.
- wb_wd  out  LANES*RADDR_W  registered destinations.
- wb_wdata  out  LANES*DATA_W  registered data.
- wb_whilo  out  1  registered HI/LO write enable.
- wb_hi, wb_lo  out  DATA_W  registered HI/LO data.
- retire_cnt  out  CNT_W  number of retired instructions.

## Operation
- Reset (asynchronous): every output goes to 0, including retire_cnt.
- Each clock edge performs exactly one action. The priority order is flush, then bubble, then hold, then advance.
  - flush=1: all register contents are zeroed, giving a bubble.
  - stall_mem=1 and stall_wb=0: a bubble is inserted (all contents zeroed).
  - stall_wb=1: contents are held, whatever the value of stall_mem.
  - Otherwise: advance, capturing the MEM inputs.
- On advance, each lane is captured as follows:
  - If mem_valid[i]=0, every field of lane i is stored as 0.
  - wb_wreg[i] = mem_valid[i] & mem_wreg[i] & (mem_wd[i] != 0). A write to r0 is dropped here.
  - Collapse: if some lane j>i also has a surviving write with mem_wd[j]==mem_wd[i], then wb_wreg[i]=0. The youngest write wins. wb_wd and wb_wdata for lane i are still captured.
  - wb_whilo = mem_whilo & |mem_valid. wb_hi and wb_lo are captured unconditionally on advance.
- Retire counter:
  - On an advance edge it adds popcount(mem_valid).
  - It does not change on flush, bubble or hold edges.
  - It wraps modulo 2^CNT_W with no saturation.
  - cnt_clr=1 forces retire_cnt to 0 on that edge and overrides any same-cycle increment.

## Timing
- Latency is 1 cycle from MEM inputs to wb_* outputs. All outputs come directly from flops with no combinational path from inputs.
- A hold keeps outputs stable for as many cycles as stall_wb stays high. The first edge with stall_wb=0 then either advances or inserts a bubble, depending on stall_mem.
- If reset is asserted mid-hold, outputs clear immediately without waiting for a clock edge. The first edge after reset deasserts obeys the normal priority order.
- A flush during a hold discards the held instruction; flush wins.
- When cnt_clr and flush occur together, the counter becomes 0 and the contents are zeroed.

## Structure
- cpu_pkg holds the DATA_W and RADDR_W defaults, the ZERO_WORD and NOP_REG constants, and a popcount function used for the counter increment.
- One sub-module, mem_wb_lane: the per-lane valid/wreg/wd/wdata flop with clear and enable inputs, instantiated LANES times by a generate loop. The top level contains the control decode, the collapse logic, the HI/LO flops and the counter.

## Test plan
- Reset and advance:
  - Stimulus: assert rst mid-cycle with outputs nonzero.
  - Required: all outputs go to 0 before the next edge.
  - Then: release rst and drive lane0 valid, wd=3, wdata=0x12345678, wreg=1.
  - Required: one edge later wb_wd[0]=3, wb_wdata[0]=0x12345678, wb_wreg[0]=1, retire_cnt=1.
- Collapse:
  - Stimulus: both lanes valid, wreg=1, wd=7, data 0xA and 0xB.
  - Required: wb_wreg=2'b10, wb_wdata[1]=0xB.
  - Stimulus: both lanes write wd=0.
  - Required: wb_wreg=2'b00, retire_cnt increments by 2.
- Stall:
  - Stimulus: stall_wb=1 for 3 cycles while inputs change.
  - Required: outputs hold the prior values and the counter is unchanged.
  - Stimulus: then stall_mem=1, stall_wb=0 for one edge.
  - Required: all outputs 0.
- Flush priority:
  - Stimulus: flush=1 together with stall_wb=1 and valid inputs.
  - Required: outputs 0, counter unchanged.
- HI/LO:
  - Stimulus: mem_whilo=1, hi=0xFFFF0000, lo=0x0000FFFF, lane0 valid.
  - Required: wb_whilo=1 with the same data.
  - Stimulus: mem_whilo=1 with both lanes invalid.
  - Required: wb_whilo=0.
- Counter:
  - Stimulus: with CNT_W=4, preload 14, then one advance with 2 valid lanes.
  - Required: retire_cnt=0 (wrap).
  - Stimulus: cnt_clr=1 together with an advance of 2 valid lanes.
  - Required: retire_cnt=0.
